// File: rtl/pc_gen_pkg.sv
// Shared CPU fetch parameters: default reset/exception addresses, the legal
// instruction-memory window, next-PC select encodings and redirect-buffer states.
package pc_gen_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_TOP   = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        NPC_SEL_SEQ  = 3'd0,
        NPC_SEL_BR   = 3'd1,
        NPC_SEL_J    = 3'd2,
        NPC_SEL_BUF  = 3'd3,
        NPC_SEL_EXC  = 3'd4,
        NPC_SEL_ERET = 3'd5,
        NPC_SEL_HOLD = 3'd6
    } npc_sel_e;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between decode/CP0 (master) and the PC generator (slave).
// No handshake: every request is a single-cycle level sampled on the rising clock edge.
interface pc_gen_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch;
    logic [WIDTH-1:0] branch_addr;
    logic             jump;
    logic [WIDTH-1:0] jump_addr;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic             redir_pending;
    logic             fetch_adel;

    modport master (
        output stall, branch, branch_addr, jump, jump_addr, exc_req, eret_req, epc,
        input  pc, pc_inc, redir_pending, fetch_adel
    );

    modport slave (
        input  stall, branch, branch_addr, jump, jump_addr, exc_req, eret_req, epc,
        output pc, pc_inc, redir_pending, fetch_adel
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: holds a branch/jump target resolved while fetch is
// stalled until the stall releases. Jump beats branch; a newer capture overwrites.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_addr,
    output logic             valid,
    output logic [WIDTH-1:0] target,
    output buf_state_e       state
);

    buf_state_e state_next;
    logic       capture;

    assign capture = stall & ~flush & (jump | branch);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= BUF_EMPTY;
            target <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                target <= jump ? jump_addr : branch_addr;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (capture) state_next = BUF_FULL;
            BUF_FULL:  if (flush || !stall) state_next = BUF_EMPTY;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    always_comb begin
        valid = (state == BUF_FULL);
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: next-PC select mux and PC register.
// Build option PC_ALIGN_CHECK_EN adds a registered fetch address-error flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(DEF_EXC_VEC),
    parameter int unsigned      INC      = 4,
    parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(DEF_IM_BASE),
    parameter logic [WIDTH-1:0] IM_TOP   = WIDTH'(DEF_IM_TOP)
) (
    input  logic   clk,
    input  logic   reset_n,
    pc_gen_if.slave bus
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] buf_target;
    logic             buf_valid;
    buf_state_e       buf_state;
    npc_sel_e         sel;

    pc_redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (bus.stall),
        .flush       (bus.exc_req | bus.eret_req),
        .jump        (bus.jump),
        .jump_addr   (bus.jump_addr),
        .branch      (bus.branch),
        .branch_addr (bus.branch_addr),
        .valid       (buf_valid),
        .target      (buf_target),
        .state       (buf_state)
    );

    assign bus.pc            = pc_q;
    assign bus.pc_inc        = pc_q + WIDTH'(INC);
    assign bus.redir_pending = buf_valid;

    // Exceptions and ERET override a stall; a live redirect beats the buffered one.
    always_comb begin
        sel = NPC_SEL_SEQ;
        if (bus.eret_req)              sel = NPC_SEL_ERET;
        else if (bus.exc_req)          sel = NPC_SEL_EXC;
        else if (bus.stall)            sel = NPC_SEL_HOLD;
        else if (bus.jump)             sel = NPC_SEL_J;
        else if (bus.branch)           sel = NPC_SEL_BR;
        else if (buf_state == BUF_FULL) sel = NPC_SEL_BUF;
    end

    always_comb begin
        pc_next = bus.pc_inc;
        case (sel)
            NPC_SEL_ERET: pc_next = bus.epc;
            NPC_SEL_EXC:  pc_next = EXC_VEC;
            NPC_SEL_HOLD: pc_next = pc_q;
            NPC_SEL_J:    pc_next = bus.jump_addr;
            NPC_SEL_BR:   pc_next = bus.branch_addr;
            NPC_SEL_BUF:  pc_next = buf_target;
            default:      pc_next = bus.pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) pc_q <= RESET_PC;
        else          pc_q <= pc_next;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q;

    // Evaluated on pc_next so the flag lines up with the pc it describes.
    always_ff @(posedge clk) begin
        if (!reset_n) adel_q <= 1'b0;
        else          adel_q <= (pc_next[1:0] != 2'b00) | (pc_next < IM_BASE) | (pc_next > IM_TOP);
    end

    assign bus.fetch_adel = adel_q;
`else
    logic unused_im_window;

    assign unused_im_window = ^{IM_BASE, IM_TOP};
    assign bus.fetch_adel   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run,
// all checked against a behavioural next-PC model with a queue as the redirect buffer.
module tb_pc_gen;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    logic [31:0] m_pc;
    logic [31:0] m_buf[$];
    logic        m_adel;
    logic [31:0] exp_q[$];

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.stall = 0; bus.branch = 0; bus.jump = 0; bus.exc_req = 0; bus.eret_req = 0;
        bus.branch_addr = '0; bus.jump_addr = '0; bus.epc = '0;
    endtask

    // Advance one clock and apply the fetch rules to the model with the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_pc = 32'h0000_3000; m_buf.delete();
        end else if (bus.eret_req) begin
            m_pc = bus.epc; m_buf.delete();
        end else if (bus.exc_req) begin
            m_pc = 32'h0000_4180; m_buf.delete();
        end else if (bus.stall) begin
            if (bus.jump || bus.branch) begin
                m_buf.delete();
                m_buf.push_back(bus.jump ? bus.jump_addr : bus.branch_addr);
            end
        end else if (bus.jump) begin
            m_pc = bus.jump_addr; m_buf.delete();
        end else if (bus.branch) begin
            m_pc = bus.branch_addr; m_buf.delete();
        end else if (m_buf.size() != 0) begin
            m_pc = m_buf.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
`ifdef PC_ALIGN_CHECK_EN
        m_adel = reset_n && ((m_pc % 4) != 0 || m_pc < 32'h3000 || m_pc > 32'h6FFC);
`else
        m_adel = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; idle(); bus.jump = 1; bus.jump_addr = 32'h5555_5550;
        tick(); tick();
        n_cmp++; if (bus.pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h3000); end
        n_cmp++; if (bus.redir_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.redir_pending); end
        n_cmp++; if (bus.fetch_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel got %b want 0", bus.fetch_adel); end
        reset_n = 1; idle();
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_3004) begin n_fail++; $display("FAIL seq1 got %h want %h", bus.pc, 32'h3004); end
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_3008) begin n_fail++; $display("FAIL seq2 got %h want %h", bus.pc, 32'h3008); end
        n_cmp++; if (bus.pc_inc !== 32'h0000_300C) begin n_fail++; $display("FAIL pc_inc got %h want %h", bus.pc_inc, 32'h300C); end
    endtask

    task automatic test_jump();
        tick(); tick();
        n_cmp++; if (bus.pc !== 32'h0000_3010) begin n_fail++; $display("FAIL pre_jump got %h want %h", bus.pc, 32'h3010); end
        bus.jump = 1; bus.jump_addr = 32'h0000_3100;
        tick(); idle();
        n_cmp++; if (bus.pc !== 32'h0000_3100) begin n_fail++; $display("FAIL jump got %h want %h", bus.pc, 32'h3100); end
    endtask

    task automatic test_stall_redirect();
        bus.jump = 1; bus.jump_addr = 32'h0000_3020; tick(); idle();
        bus.stall = 1; bus.branch = 1; bus.branch_addr = 32'h0000_3200;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.branch = 0;
            n_cmp++; if (bus.pc !== 32'h0000_3020) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, bus.pc, 32'h3020); end
            n_cmp++; if (bus.redir_pending !== 1'b1) begin n_fail++; $display("FAIL stall_pending[%0d] got %b want 1", i, bus.redir_pending); end
        end
        bus.stall = 0;
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_3200) begin n_fail++; $display("FAIL buf_release got %h want %h", bus.pc, 32'h3200); end
        n_cmp++; if (bus.redir_pending !== 1'b0) begin n_fail++; $display("FAIL buf_release_pending got %b want 0", bus.redir_pending); end
    endtask

    task automatic test_collision();
        bus.stall = 1; bus.branch = 1; bus.branch_addr = 32'h0000_3200; tick(); bus.branch = 0;
        n_cmp++; if (bus.redir_pending !== 1'b1) begin n_fail++; $display("FAIL coll_fill got %b want 1", bus.redir_pending); end
        bus.exc_req = 1; tick();
        n_cmp++; if (bus.pc !== 32'h0000_4180) begin n_fail++; $display("FAIL exc_vec got %h want %h", bus.pc, 32'h4180); end
        n_cmp++; if (bus.redir_pending !== 1'b0) begin n_fail++; $display("FAIL exc_flush got %b want 0", bus.redir_pending); end
        bus.eret_req = 1; bus.epc = 32'h0000_3024; tick(); idle();
        n_cmp++; if (bus.pc !== 32'h0000_3024) begin n_fail++; $display("FAIL eret_wins got %h want %h", bus.pc, 32'h3024); end
    endtask

    task automatic test_overwrite_wrap();
        bus.stall = 1; bus.jump = 1; bus.jump_addr = 32'h0000_3300; tick();
        bus.jump_addr = 32'h0000_3400; tick(); idle();
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_3400) begin n_fail++; $display("FAIL overwrite got %h want %h", bus.pc, 32'h3400); end
        bus.jump = 1; bus.jump_addr = 32'hFFFF_FFFC; tick(); idle();
        n_cmp++; if (bus.pc_inc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_inc got %h want 0", bus.pc_inc); end
        tick();
        n_cmp++; if (bus.pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap got %h want 0", bus.pc); end
    endtask

    task automatic test_adel();
        logic [31:0] addrs[3];
        logic        exp_adel[3];
        addrs = '{32'h0000_3002, 32'h0000_7000, 32'h0000_3004};
`ifdef PC_ALIGN_CHECK_EN
        exp_adel = '{1'b1, 1'b1, 1'b0};
`else
        exp_adel = '{1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 3; i++) begin
            bus.jump = 1; bus.jump_addr = addrs[i]; tick(); idle();
            n_cmp++; if (bus.pc !== addrs[i]) begin n_fail++; $display("FAIL adel_pc[%0d] got %h want %h", i, bus.pc, addrs[i]); end
            n_cmp++; if (bus.fetch_adel !== exp_adel[i]) begin n_fail++; $display("FAIL adel[%0d] got %b want %b", i, bus.fetch_adel, exp_adel[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        for (int i = 0; i < 400; i++) begin
            reset_n         = ($urandom_range(0, 49) != 0);
            bus.stall       = ($urandom_range(0, 2) == 0);
            bus.branch      = ($urandom_range(0, 3) == 0);
            bus.jump        = ($urandom_range(0, 4) == 0);
            bus.exc_req     = ($urandom_range(0, 14) == 0);
            bus.eret_req    = ($urandom_range(0, 19) == 0);
            bus.branch_addr = 32'h3000 + ($urandom_range(0, 16383) & 32'hFFFF_FFFD);
            bus.jump_addr   = 32'h3000 + $urandom_range(0, 16383);
            bus.epc         = $urandom;
            tick();
            exp_q.push_back(m_pc);
            exp_pc = exp_q.pop_front();
            n_cmp++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL rand_pc[%0d] got %h want %h", i, bus.pc, exp_pc); end
            n_cmp++; if (bus.pc_inc !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rand_inc[%0d] got %h want %h", i, bus.pc_inc, exp_pc + 32'd4); end
            n_cmp++; if (bus.redir_pending !== (m_buf.size() != 0)) begin n_fail++; $display("FAIL rand_pending[%0d] got %b want %b", i, bus.redir_pending, m_buf.size() != 0); end
            n_cmp++; if (bus.fetch_adel !== m_adel) begin n_fail++; $display("FAIL rand_adel[%0d] got %b want %b", i, bus.fetch_adel, m_adel); end
        end
        reset_n = 1; idle();
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        m_pc = '0; m_adel = 1'b0;
        reset_n = 0; idle();
        @(negedge clk);
        test_reset();
        test_jump();
        test_stall_redirect();
        test_collision();
        test_overwrite_wrap();
        test_adel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
